frame_sched: RTL and testbench



---
 rtl/frame_sched_pkg.sv | 33 +++
 rtl/frame_sched_rr_arbiter.sv | 31 +++
 rtl/frame_sched.sv | 144 ++++++++++++++
 tb/tb_frame_sched.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_sched_pkg.sv
// Shared types and field map for the frame scheduler: FSM states, frame layout,
// field positions and error codes.
package frame_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  localparam int TGT_MSB  = 24;
  localparam int TGT_LSB  = 22;
  localparam int RW_BIT   = 16;
  localparam int OPID_MSB = 7;
  localparam int OPID_LSB = 0;

  localparam logic [1:0] ERR_BAD_TGT = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef struct packed {
    logic [6:0] rsvd;
    logic [2:0] tgt;
    logic [4:0] addr;
    logic       wr_rd_s;
    logic [7:0] wdata;
    logic [7:0] op_id;
  } frame_t;

  function automatic logic tgt_valid(input logic [2:0] tgt, input int num_inst);
    return int'(tgt) < num_inst;
  endfunction

endpackage

// File: rtl/frame_sched_rr_arbiter.sv
// Combinational round-robin arbiter: search begins one past last_grant and wraps.
// Zero latency; no backpressure of its own, the caller owns last_grant.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  int   pos;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    for (int k = 1; k <= N; k++) begin
      pos = (int'(last_grant) + k) % N;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        grant_idx  = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/frame_sched.sv
// Round-robin frame scheduler: handshake in T, one-hot load + frame in T+1;
// reads block further grants until a matching completion or a timeout.
module frame_sched
  import frame_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int NUM_SW_INST = 5,
  parameter int FRAME_WIDTH = 32,
  parameter int TIMEOUT     = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*FRAME_WIDTH-1:0] req_frame,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_SW_INST-1:0]         load_out,
  output logic [FRAME_WIDTH-1:0]         frame_out,
  input  logic                           rd_done,
  input  logic [7:0]                     rd_done_id,
  output logic                           err_valid,
  output logic [1:0]                     err_code,
  output logic [7:0]                     err_op_id,
  output logic                           busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT) + 1;

  state_t                   state, state_nxt;
  logic [IW-1:0]            last_grant, last_grant_nxt;
  logic [CW-1:0]            cnt, cnt_nxt;
  logic [NUM_SW_INST-1:0]   load_nxt;
  logic [FRAME_WIDTH-1:0]   frame_nxt;
  logic                     err_valid_nxt;
  logic [1:0]               err_code_nxt;
  logic [7:0]               err_op_id_nxt;
  logic                     busy_nxt;

  logic [NUM_REQ-1:0]       grant;
  logic [IW-1:0]            grant_idx;
  frame_t                   in_frame;
  logic                     handshake;
  logic [2:0]               cur_tgt;
  logic [7:0]               cur_op_id;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  always_comb begin
    in_frame = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) in_frame = frame_t'(req_frame[i*FRAME_WIDTH +: FRAME_WIDTH]);
    end
  end

  assign req_ready = (state == IDLE) ? grant : '0;
  assign handshake = (state == IDLE) && (|grant);

  // frame_out doubles as the capture register for the in-flight frame
  assign cur_tgt   = frame_out[TGT_MSB:TGT_LSB];
  assign cur_op_id = frame_out[OPID_MSB:OPID_LSB];

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt;
    load_nxt       = '0;
    frame_nxt      = frame_out;
    err_valid_nxt  = 1'b0;
    err_code_nxt   = err_code;
    err_op_id_nxt  = err_op_id;

    case (state)
      IDLE: begin
        if (handshake) begin
          frame_nxt      = FRAME_WIDTH'(in_frame);
          last_grant_nxt = grant_idx;
          state_nxt      = ISSUE;
          if (tgt_valid(in_frame.tgt, NUM_SW_INST)) begin
            load_nxt = NUM_SW_INST'(1) << in_frame.tgt;
          end else begin
            err_valid_nxt = 1'b1;
            err_code_nxt  = ERR_BAD_TGT;
            err_op_id_nxt = in_frame.op_id;
          end
        end
      end

      ISSUE: begin
        cnt_nxt = '0;
        if (!tgt_valid(cur_tgt, NUM_SW_INST) || frame_out[RW_BIT]) state_nxt = IDLE;
        else                                                       state_nxt = WAIT_RD;
      end

      WAIT_RD: begin
        // a match in the last allowed cycle takes priority over the timeout
        if (rd_done && (rd_done_id == cur_op_id)) begin
          state_nxt = IDLE;
        end else begin
          if (cnt != CW'(TIMEOUT)) cnt_nxt = cnt + CW'(1);
          if (cnt >= CW'(TIMEOUT - 1)) begin
            state_nxt     = IDLE;
            err_valid_nxt = 1'b1;
            err_code_nxt  = ERR_TIMEOUT;
            err_op_id_nxt = cur_op_id;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      cnt        <= '0;
      load_out   <= '0;
      frame_out  <= '0;
      err_valid  <= 1'b0;
      err_code   <= '0;
      err_op_id  <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
      load_out   <= load_nxt;
      frame_out  <= frame_nxt;
      err_valid  <= err_valid_nxt;
      err_code   <= err_code_nxt;
      err_op_id  <= err_op_id_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_frame_sched.sv
// Directed bench for frame_sched: writes, round-robin order, read completion,
// read timeout, bad target and reset in WAIT_RD.
module tb_frame_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_frame;
  logic [3:0]   req_ready;
  logic [4:0]   load_out;
  logic [31:0]  frame_out;
  logic         rd_done;
  logic [7:0]   rd_done_id;
  logic         err_valid;
  logic [1:0]   err_code;
  logic [7:0]   err_op_id;
  logic         busy;

  int n_chk = 0;
  int n_err = 0;
  logic seen_err;

  frame_sched #(.NUM_REQ(4), .NUM_SW_INST(5), .FRAME_WIDTH(32), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_frame  (req_frame),
    .req_ready  (req_ready),
    .load_out   (load_out),
    .frame_out  (frame_out),
    .rd_done    (rd_done),
    .rd_done_id (rd_done_id),
    .err_valid  (err_valid),
    .err_code   (err_code),
    .err_op_id  (err_op_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mkf(input logic [2:0] tgt, input logic wr, input logic [7:0] op);
    return {7'd0, tgt, 5'd3, wr, 8'hC3, op};
  endfunction

  task automatic set_frame(input int i, input logic [31:0] f);
    req_frame[i*32 +: 32] = f;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    rd_done    = 1'b0;
    rd_done_id = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0]  rr_rdy  [5];
  logic [4:0]  rr_load [5];
  logic [31:0] rr_frm  [5];

  initial begin
    req_frame = '0;
    do_reset();

    // reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_load", load_out, 5'd0);
    chk("rst_frame", frame_out, 32'd0);
    chk("rst_err", {err_valid, err_code, err_op_id}, 11'd0);
    chk("rst_rdy", req_ready, 4'd0);

    // single write, target 1
    set_frame(0, 32'h0049_AB11);
    req_valid = 4'b0001;
    #1 chk("wr_rdy", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    chk("wr_load", load_out, 5'b00010);
    chk("wr_frame", frame_out, 32'h0049_AB11);
    chk("wr_busy_t1", busy, 1'b1);
    @(negedge clk);
    chk("wr_load_off", load_out, 5'b00000);
    chk("wr_busy_t2", busy, 1'b0);
    chk("wr_frame_hold", frame_out, 32'h0049_AB11);

    // round robin among 0,1,3 from reset
    do_reset();
    set_frame(0, mkf(3'd0, 1'b1, 8'h10));
    set_frame(1, mkf(3'd2, 1'b1, 8'h11));
    set_frame(2, mkf(3'd3, 1'b1, 8'h12));
    set_frame(3, mkf(3'd4, 1'b1, 8'h13));
    rr_rdy  = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010};
    rr_load = '{5'b00001, 5'b00100, 5'b10000, 5'b00001, 5'b00100};
    rr_frm  = '{mkf(3'd0, 1'b1, 8'h10), mkf(3'd2, 1'b1, 8'h11), mkf(3'd4, 1'b1, 8'h13),
                mkf(3'd0, 1'b1, 8'h10), mkf(3'd2, 1'b1, 8'h11)};
    req_valid = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      #1 chk("rr_rdy", req_ready, rr_rdy[i]);
      @(negedge clk);
      chk("rr_load", load_out, rr_load[i]);
      chk("rr_frame", frame_out, rr_frm[i]);
      chk("rr_rdy_issue", req_ready, 4'b0000);
      @(negedge clk);
    end
    req_valid = '0;
    @(negedge clk);

    // read completion: mismatched id ignored, matching id ends the wait
    set_frame(2, mkf(3'd2, 1'b0, 8'h5A));
    req_valid = 4'b0100;
    #1 chk("rdc_rdy", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    chk("rdc_load", load_out, 5'b00100);
    seen_err = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      seen_err   = seen_err | err_valid;
      rd_done    = (k == 3) || (k == 5);
      rd_done_id = (k == 3) ? 8'h33 : 8'h5A;
    end
    chk("rdc_busy_wait", busy, 1'b1);
    @(negedge clk);
    rd_done  = 1'b0;
    seen_err = seen_err | err_valid;
    chk("rdc_busy_done", busy, 1'b0);
    chk("rdc_no_err", seen_err, 1'b0);

    // read timeout after 16 unmatched WAIT_RD cycles
    set_frame(3, mkf(3'd0, 1'b0, 8'h77));
    req_valid = 4'b1000;
    @(negedge clk);
    req_valid = '0;
    seen_err  = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      seen_err = seen_err | err_valid;
    end
    chk("to_busy_last", busy, 1'b1);
    chk("to_no_early_err", seen_err, 1'b0);
    @(negedge clk);
    chk("to_err_valid", err_valid, 1'b1);
    chk("to_err_code", err_code, 2'd2);
    chk("to_err_id", err_op_id, 8'h77);
    chk("to_busy_after", busy, 1'b0);
    @(negedge clk);
    chk("to_err_pulse", err_valid, 1'b0);

    // matching completion in the final allowed cycle wins over timeout
    set_frame(3, mkf(3'd1, 1'b0, 8'h21));
    req_valid = 4'b1000;
    @(negedge clk);
    req_valid = '0;
    seen_err  = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      seen_err = seen_err | err_valid;
    end
    rd_done    = 1'b1;
    rd_done_id = 8'h21;
    @(negedge clk);
    rd_done  = 1'b0;
    seen_err = seen_err | err_valid;
    chk("last_match_no_err", seen_err, 1'b0);
    chk("last_match_busy", busy, 1'b0);

    // bad target: error in ISSUE, next requester served two cycles later
    set_frame(1, mkf(3'd6, 1'b1, 8'h66));
    set_frame(2, mkf(3'd3, 1'b1, 8'h42));
    req_valid = 4'b0110;
    #1 chk("bad_rdy", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = 4'b0100;
    chk("bad_load", load_out, 5'b00000);
    chk("bad_err_valid", err_valid, 1'b1);
    chk("bad_err_code", err_code, 2'd1);
    chk("bad_err_id", err_op_id, 8'h66);
    @(negedge clk);
    #1 chk("bad_next_rdy", req_ready, 4'b0100);
    chk("bad_err_pulse", err_valid, 1'b0);
    @(negedge clk);
    req_valid = '0;
    chk("bad_next_load", load_out, 5'b01000);
    chk("bad_next_frame", frame_out, mkf(3'd3, 1'b1, 8'h42));
    @(negedge clk);

    // reset while waiting for a read
    set_frame(0, mkf(3'd1, 1'b0, 8'h99));
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_wr_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rstw_busy", busy, 1'b0);
    chk("rstw_load", load_out, 5'd0);
    chk("rstw_frame", frame_out, 32'd0);
    chk("rstw_err", {err_valid, err_code, err_op_id}, 11'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_frame(0, mkf(3'd2, 1'b1, 8'h01));
    set_frame(3, mkf(3'd4, 1'b1, 8'h03));
    req_valid = 4'b1001;
    #1 chk("rstw_first_rdy", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    chk("rstw_first_load", load_out, 5'b00100);
    chk("rstw_no_err", err_valid, 1'b0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
